fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch unit and its buffers.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam int OPCODE_W = 7;
  localparam int RD_W     = 5;
  localparam int FUNCT3_W = 3;
  localparam int RS_W     = 5;
  localparam int FUNCT7_W = 7;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head word is visible combinationally.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_rdata  = r_mem[r_rd_ptr];

  // A push into a full buffer is accepted only when the head leaves in the same cycle.
  assign w_do_push = i_push && !i_flush && (!o_full || i_pop);
  assign w_do_pop  = i_pop && !i_flush && !o_empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Credit-based instruction fetch: issues word fetches, buffers in-order responses
// and discards responses that belong to requests made before a redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        redirect,
  input  logic [31:0] redirectPC,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemGnt,
  input  logic        imemRvalid,
  input  logic [31:0] imemRdata,
  output logic        instrValid,
  input  logic        instrReady,
  output logic [31:0] instruction,
  output logic [31:0] instrPC
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] L_DEPTH = (CW + 1)'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_drop_count;

  logic [CW-1:0] w_outstanding;
  logic [CW-1:0] w_buf_count;
  logic [CW:0]   w_inflight;
  logic          w_grant;
  logic          w_drop_resp;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_fifo_full;
  logic          w_pcq_full;
  logic          w_pcq_empty;
  logic [31:0]   w_resp_pc;
  fetch_entry_t  w_entry;
  fetch_entry_t  w_head;
  logic [4:0]    w_unused;

  assign w_inflight  = {1'b0, w_outstanding} + {1'b0, w_buf_count};
  assign imemReq     = rstn && !redirect && (w_inflight < L_DEPTH);
  assign imemAddr    = r_fetch_pc;
  assign w_grant     = imemReq && imemGnt;

  assign w_drop_resp = imemRvalid && (redirect || (r_drop_count != '0));
  assign w_push      = imemRvalid && !w_drop_resp;
  assign w_pop       = instrValid && instrReady && !redirect;
  assign w_entry     = {imemRdata, w_resp_pc};

  assign instrValid  = !w_empty;
  assign instruction = w_empty ? 32'd0 : w_head.instr;
  assign instrPC     = w_empty ? 32'd0 : w_head.pc;

  assign w_unused    = {w_pcq_full, w_pcq_empty, w_fifo_full, redirectPC[1:0]};

  // Addresses of granted requests; every response, kept or dropped, retires one entry.
  fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_queue (
    .clk     (clk),
    .rstn    (rstn),
    .i_flush (1'b0),
    .i_push  (w_grant),
    .i_wdata (r_fetch_pc),
    .i_pop   (imemRvalid),
    .o_rdata (w_resp_pc),
    .o_full  (w_pcq_full),
    .o_empty (w_pcq_empty),
    .o_count (w_outstanding)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instr_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_flush (redirect),
    .i_push  (w_push),
    .i_wdata (w_entry),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_empty),
    .o_count (w_buf_count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fetch_pc   <= RESET_PC;
      r_drop_count <= '0;
    end else if (redirect) begin
      // No grant can happen now, so only this cycle's response reduces the stale count.
      r_fetch_pc   <= {redirectPC[31:2], 2'b00};
      r_drop_count <= w_outstanding - CW'(imemRvalid);
    end else begin
      if (w_grant) r_fetch_pc <= next_pc(r_fetch_pc);
      if (imemRvalid && (r_drop_count != '0)) r_drop_count <= r_drop_count - 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirects, address wrap and reset.
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rstn;
  logic        redirect;
  logic [31:0] redirectPC;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt;
  logic        imemRvalid;
  logic [31:0] imemRdata;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instruction;
  logic [31:0] instrPC;

  int n_checks = 0;
  int n_errors = 0;
  int n_grants = 0;
  int n_pops   = 0;

  logic [31:0] exp_addr;
  logic [31:0] exp_pc;
  logic        mem_en;
  logic        mem_g;
  logic [31:0] mem_a;
  logic [31:0] mem_ra;
  logic [31:0] pend[$];

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .redirect    (redirect),
    .redirectPC  (redirectPC),
    .imemReq     (imemReq),
    .imemAddr    (imemAddr),
    .imemGnt     (imemGnt),
    .imemRvalid  (imemRvalid),
    .imemRdata   (imemRdata),
    .instrValid  (instrValid),
    .instrReady  (instrReady),
    .instruction (instruction),
    .instrPC     (instrPC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // In-order memory: a request granted at edge N can answer at edge N+1; word = ~address.
  always @(posedge clk) begin
    mem_g = imemReq && imemGnt;
    mem_a = imemAddr;
    #1;
    if (!rstn) begin
      pend.delete();
      imemRvalid = 1'b0;
      imemRdata  = 32'd0;
    end else begin
      if (mem_g) pend.push_back(mem_a);
      if (mem_en && pend.size() > 0) begin
        mem_ra     = pend.pop_front();
        imemRvalid = 1'b1;
        imemRdata  = ~mem_ra;
      end else begin
        imemRvalid = 1'b0;
        imemRdata  = 32'd0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic observe();
    if (imemReq && imemGnt) begin
      $display("grant   addr=%08h", imemAddr);
      check("fetch_addr", imemAddr, exp_addr);
      exp_addr = exp_addr + 32'd4;
      n_grants++;
    end
    if (instrValid && instrReady && !redirect) begin
      $display("deliver pc=%08h instr=%08h", instrPC, instruction);
      check("instr_pc", instrPC, exp_pc);
      check("instr_word", instruction, ~exp_pc);
      exp_pc = exp_pc + 32'd4;
      n_pops++;
    end
  endtask

  task automatic tick();
    #1;
    observe();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (instrValid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, instrValid, 1'b1);
  endtask

  task automatic drain();
    imemGnt = 1'b0;
    repeat (6) tick();
    check("drained_empty", instrValid, 1'b0);
    imemGnt = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [31:0] head_pc;

    rstn = 1'b0; redirect = 1'b0; redirectPC = 32'd0;
    imemGnt = 1'b1; instrReady = 1'b1; mem_en = 1'b1;
    exp_addr = RESET_PC; exp_pc = RESET_PC;
    repeat (3) @(negedge clk);
    check("rst_req", imemReq, 1'b0);
    check("rst_valid", instrValid, 1'b0);
    check("rst_instr", instruction, 32'd0);
    check("rst_pc", instrPC, 32'd0);

    // Reset release and steady streaming
    rstn = 1'b1;
    #1;
    check("first_req", imemReq, 1'b1);
    check("first_addr", imemAddr, RESET_PC);
    for (int k = 0; k < 10; k++) begin
      if (k < 2) check("fill_latency_valid", instrValid, 1'b0);
      else begin
        check("stream_valid", instrValid, 1'b1);
        check("stream_req", imemReq, 1'b1);
      end
      tick();
    end

    // Decoder stall for 10 cycles
    instrReady = 1'b0;
    base = n_grants;
    head_pc = exp_pc;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("stall_valid", instrValid, 1'b1);
      check("stall_head_pc", instrPC, head_pc);
      check("stall_head_word", instruction, ~head_pc);
    end
    check("stall_grants", n_grants - base, 2);
    check("stall_req_low", imemReq, 1'b0);
    instrReady = 1'b1;
    base = n_pops;
    repeat (8) tick();
    check("release_pops", n_pops - base, 8);

    // Redirect with two requests in flight
    drain();
    mem_en = 1'b0;
    tick();
    tick();
    redirect = 1'b1; redirectPC = 32'h0000_0103; mem_en = 1'b1;
    #1;
    check("c_redir_req_low", imemReq, 1'b0);
    tick();
    redirect = 1'b0; exp_addr = 32'h0000_0100; exp_pc = 32'h0000_0100;
    check("c_valid_after_redir", instrValid, 1'b0);
    check("c_restart_addr", imemAddr, 32'h0000_0100);
    wait_valid("c_wait_valid");
    check("c_first_pc", instrPC, 32'h0000_0100);

    // Redirect coinciding with a response and a pop
    repeat (4) tick();
    redirect = 1'b1; redirectPC = 32'h0000_0200;
    #1;
    check("d_pre_valid", instrValid, 1'b1);
    check("d_redir_req_low", imemReq, 1'b0);
    tick();
    redirect = 1'b0; exp_addr = 32'h0000_0200; exp_pc = 32'h0000_0200;
    check("d_valid_after_redir", instrValid, 1'b0);
    check("d_restart_addr", imemAddr, 32'h0000_0200);
    wait_valid("d_wait_valid");
    check("d_first_pc", instrPC, 32'h0000_0200);

    // Address wrap at the top of memory
    repeat (3) tick();
    redirect = 1'b1; redirectPC = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0; exp_addr = 32'hFFFF_FFF8; exp_pc = 32'hFFFF_FFF8;
    check("e_addr0", imemAddr, 32'hFFFF_FFF8);
    tick();
    check("e_addr1", imemAddr, 32'hFFFF_FFFC);
    tick();
    check("e_addr2", imemAddr, 32'h0000_0000);
    wait_valid("e_wait_valid");
    check("e_first_pc", instrPC, 32'hFFFF_FFF8);
    repeat (6) tick();

    // Reset with two requests outstanding and one buffered
    drain();
    instrReady = 1'b0;
    tick();
    mem_en = 1'b0;
    tick();
    tick();
    check("f_pre_valid", instrValid, 1'b1);
    rstn = 1'b0;
    #1;
    check("f_rst_req", imemReq, 1'b0);
    check("f_rst_valid", instrValid, 1'b0);
    check("f_rst_instr", instruction, 32'd0);
    check("f_rst_pc", instrPC, 32'd0);
    repeat (2) @(negedge clk);
    exp_addr = RESET_PC; exp_pc = RESET_PC;
    instrReady = 1'b1; mem_en = 1'b1;
    rstn = 1'b1;
    #1;
    check("f_restart_req", imemReq, 1'b1);
    check("f_restart_addr", imemAddr, RESET_PC);
    base = n_pops;
    repeat (8) tick();
    check("f_pops", n_pops - base, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
